i2s_rx: RTL and testbench

- I2S receive counterpart to the playback path: captures serial audio from an external ADC/codec acting as bus master (drives BCK and WS).
- Deserialises MSB-first left/right words and packs each stereo pair into a small FIFO.
- A downstream consumer (SD write path, loopback to the DAC driver) pops the FIFO.
- Runs entirely on the 50 MHz system clock; BCK is oversampled, never used as a clock.

---
 rtl/i2s_rx_pkg.sv | 24 ++
 rtl/i2s_rx_fifo.sv | 73 +++++++
 rtl/i2s_rx.sv | 205 ++++++++++++++++++++
 tb/tb_i2s_rx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_pkg
//  Description : Shared constants for the I2S capture path: receiver state
//                encoding, default sample width and word-select polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_rx_pkg;

    // Default number of bits kept per channel
    localparam int DEF_DATA_W = 16;

    // Word-select level identifying each channel
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Receiver FSM state encoding (IDLE, LEFT, RIGHT)
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_LEFT  = 2'd1;
    localparam rx_state_t ST_RIGHT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/i2s_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_fifo
//  Description : Single-clock FIFO with registered read data. A push into a
//                full FIFO is dropped unless a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_dout;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == C_DEPTH);
    assign o_level   = r_level;
    assign o_dout    = r_dout;
    // A pop frees the slot the simultaneous push lands in
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers (power-of-two depth wraps naturally), occupancy and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : I2S slave receiver. Oversamples BCK/WS/DIN on the system
//                clock, deserialises left/right slots MSB first and pushes
//                each stereo pair into a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          adc_bck,
    input  logic                          adc_ws,
    input  logic                          adc_din,
    input  logic                          rd_en,
    output logic [2*DATA_W-1:0]           rd_data,
    output logic                          rd_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_flags
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] C_SLOT_FULL = CW'(DATA_W);

    logic [SYNC_STAGES-1:0] r_bck_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_bck_prev;
    logic                   r_ws_prev;

    rx_state_t              r_state;
    logic [CW-1:0]          r_count;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_left;
    logic                   r_push;
    logic [2*DATA_W-1:0]    r_push_data;
    logic                   r_overflow;
    logic                   r_frame_err;

    logic                   w_bck_s;
    logic                   w_ws_s;
    logic                   w_din_s;
    logic                   w_bck_rise;
    logic                   w_ws_edge;
    logic [CW-1:0]          w_count_inc;
    logic [DATA_W-1:0]      w_shift_dat;
    logic                   w_slot_ok;
    rx_state_t              w_state_nxt;
    logic                   w_slot_start;
    logic                   w_latch_left;
    logic                   w_push_req;
    logic                   w_ferr_set;
    logic                   w_fifo_push;
    logic                   w_fifo_full;
    logic                   w_drop;

    assign w_bck_s    = r_bck_sync[SYNC_STAGES-1];
    assign w_ws_s     = r_ws_sync[SYNC_STAGES-1];
    assign w_din_s    = r_din_sync[SYNC_STAGES-1];
    assign w_bck_rise = w_bck_s & ~r_bck_prev;
    assign w_ws_edge  = (w_ws_s != r_ws_prev);

    // Equal-length synchronisers keep BCK, WS and DIN mutually aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bck_sync <= '0;
            r_ws_sync  <= '0;
            r_din_sync <= '0;
            r_bck_prev <= 1'b0;
            r_ws_prev  <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                r_bck_sync[i] <= r_bck_sync[i-1];
                r_ws_sync[i]  <= r_ws_sync[i-1];
                r_din_sync[i] <= r_din_sync[i-1];
            end
            r_bck_sync[0] <= adc_bck;
            r_ws_sync[0]  <= adc_ws;
            r_din_sync[0] <= adc_din;
            r_bck_prev    <= w_bck_s;
            // WS history tracks even while disabled so re-enable sees no false edge
            if (w_bck_rise) begin
                r_ws_prev <= w_ws_s;
            end
        end
    end

    // Slot framing: next state and actions for the current BCK rise
    always_comb begin
        w_count_inc  = (r_count < C_SLOT_FULL) ? r_count + CW'(1) : r_count;
        // Bits beyond DATA_W are not shifted, so the MSBs survive truncation
        w_shift_dat  = (r_count < C_SLOT_FULL) ? {r_shift[DATA_W-2:0], w_din_s} : r_shift;
        w_slot_ok    = (w_count_inc == C_SLOT_FULL);
        w_state_nxt  = r_state;
        w_slot_start = 1'b0;
        w_latch_left = 1'b0;
        w_push_req   = 1'b0;
        w_ferr_set   = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (w_bck_rise) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ws_edge && (w_ws_s == WS_LEFT)) begin
                        w_state_nxt  = ST_LEFT;
                        w_slot_start = 1'b1;
                    end
                end
                ST_LEFT: begin
                    if (w_ws_edge && (w_ws_s == WS_RIGHT)) begin
                        if (w_slot_ok) begin
                            w_state_nxt  = ST_RIGHT;
                            w_latch_left = 1'b1;
                            w_slot_start = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_ferr_set  = 1'b1;
                        end
                    end
                end
                ST_RIGHT: begin
                    if (w_ws_edge && (w_ws_s == WS_LEFT)) begin
                        // This edge rise also opens the next left slot
                        w_state_nxt  = ST_LEFT;
                        w_slot_start = 1'b1;
                        w_push_req   = w_slot_ok;
                        w_ferr_set   = ~w_slot_ok;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state, bit counter, shift/latch registers and the registered push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_push  <= w_push_req;
            if (w_push_req) begin
                r_push_data <= {r_left, w_shift_dat};
            end
            if (w_latch_left) begin
                r_left <= w_shift_dat;
            end
            if (w_slot_start) begin
                r_count <= '0;
                r_shift <= '0;
            end else if (enable && w_bck_rise && (r_state != ST_IDLE)) begin
                r_count <= w_count_inc;
                r_shift <= w_shift_dat;
            end
        end
    end

    assign w_fifo_push = r_push & enable;
    assign w_drop      = w_fifo_push & w_fifo_full & ~(rd_en & ~rd_empty);

    // Sticky status flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_drop     | (r_overflow  & ~clr_flags);
            r_frame_err <= w_ferr_set | (r_frame_err & ~clr_flags);
        end
    end

    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

    i2s_rx_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_din   (r_push_data),
        .i_pop   (rd_en),
        .o_dout  (rd_data),
        .o_level (fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (rd_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx
//  Description : Self-checking bench for i2s_rx: table of single-frame
//                vectors, randomized frame streams against a frame-level
//                model, and hand-written reset/enable/overflow sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

    localparam int DATA_W      = 16;
    localparam int FIFO_DEPTH  = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              enable    = 1'b1;
    logic              adc_bck   = 1'b0;
    logic              adc_ws    = 1'b1;
    logic              adc_din   = 1'b0;
    logic              rd_en     = 1'b0;
    logic              clr_flags = 1'b0;
    logic [2*DATA_W-1:0] rd_data;
    logic              rd_empty;
    logic [LW-1:0]     fifo_level;
    logic              overflow;
    logic              frame_err;

    always #10 clk = ~clk;

    i2s_rx #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .adc_bck    (adc_bck),
        .adc_ws     (adc_ws),
        .adc_din    (adc_din),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_empty   (rd_empty),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_flags  (clr_flags)
    );

    int checks = 0;
    int errors = 0;

    // Bit stream, one entry per BCK period: channel owning the data bit,
    // the data bit, and whether to pop the FIFO as that bit completes a pair
    bit q_ch[$];
    bit q_din[$];
    bit q_pop[$];

    // Frame-level reference model
    logic [31:0] exp_q[$];
    logic [31:0] exp_popped;
    logic [31:0] exp_last;
    bit          exp_ovf;
    bit          exp_err;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          ll;
        int          rl;
        logic [31:0] exp_pair;
        bit          exp_push;
        bit          exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_slot(input bit ch, input logic [31:0] val, input int len);
        for (int b = len - 1; b >= 0; b--) begin
            q_ch.push_back(ch);
            q_din.push_back(val[b]);
            q_pop.push_back(1'b0);
        end
    endtask

    task automatic add_pad(input bit ch, input int n);
        for (int i = 0; i < n; i++) begin
            q_ch.push_back(ch);
            q_din.push_back(1'b0);
            q_pop.push_back(1'b0);
        end
    endtask

    // Frame that the model does not expect to be captured
    task automatic add_raw(input logic [31:0] l, input logic [31:0] r, input int ll, input int rl);
        add_slot(1'b0, l, ll);
        add_slot(1'b1, r, rl);
    endtask

    // Frame captured while the receiver is aligned; updates the model
    task automatic add_frame(input logic [31:0] l, input logic [31:0] r,
                             input int ll, input int rl, input bit pop);
        logic [31:0] pair;
        add_raw(l, r, ll, rl);
        if (pop) q_pop[q_pop.size()-1] = 1'b1;
        if (ll < DATA_W || rl < DATA_W) begin
            exp_err = 1'b1;
        end else begin
            pair = {16'(l >> (ll - DATA_W)), 16'(r >> (rl - DATA_W))};
            if (pop) begin
                exp_popped = exp_q.pop_front();
                exp_q.push_back(pair);
            end else if (exp_q.size() == FIFO_DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                exp_q.push_back(pair);
            end
        end
    endtask

    // Drive the stream as codec master: WS leads data by one BCK period
    task automatic play();
        for (int i = 0; i < q_din.size(); i++) begin
            @(posedge clk); #1;
            adc_bck = 1'b0;
            adc_ws  = (i + 1 < q_ch.size()) ? q_ch[i+1] : q_ch[i];
            adc_din = q_din[i];
            repeat (7) @(posedge clk);
            @(posedge clk); #1;
            adc_bck = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk); #1;
                if (q_pop[i] && k == SYNC_STAGES + 1) rd_en = 1'b1;
                if (q_pop[i] && k == SYNC_STAGES + 2) rd_en = 1'b0;
            end
        end
        q_ch.delete();
        q_din.delete();
        q_pop.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; enable = 1'b1; rd_en = 1'b0; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_empty", 32'(rd_empty), 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_flags", {30'd0, overflow, frame_err}, 32'd0);
    endtask

    task automatic drain_check(input string name);
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_one();
            chk(name, rd_data, e);
            exp_last = e;
        end
        chk({name, "_level0"}, 32'(fifo_level), 32'd0);
        chk({name, "_empty"}, 32'(rd_empty), 32'd1);
    endtask

    initial begin
        tbl[0] = '{32'h0000A5C3, 32'h00001234, 16, 16, 32'hA5C31234, 1'b1, 1'b0};
        tbl[1] = '{32'h8001FFFF, 32'h7FFE0000, 32, 32, 32'h80017FFE, 1'b1, 1'b0};
        tbl[2] = '{32'h00123456, 32'h00ABCDEF, 24, 24, 32'h1234ABCD, 1'b1, 1'b0};
        tbl[3] = '{32'h0001FFFF, 32'h00010001, 17, 17, 32'hFFFF8000, 1'b1, 1'b0};
        tbl[4] = '{32'h00000ABC, 32'h00005555, 12, 16, 32'h00000000, 1'b0, 1'b1};
        tbl[5] = '{32'h0000BEEF, 32'h00007FFF, 16, 15, 32'h00000000, 1'b0, 1'b1};
        tbl[6] = '{32'h000FFFF0, 32'h0000000F, 20, 20, 32'hFFFF0000, 1'b1, 1'b0};

        // Table: one frame, then a known-good sentinel frame proving recovery
        for (int t = 0; t < 7; t++) begin
            reset_dut();
            add_pad(1'b1, 4);
            add_raw(tbl[t].l, tbl[t].r, tbl[t].ll, tbl[t].rl);
            add_raw(32'h0F0F, 32'hF0F0, 16, 16);
            add_pad(1'b0, 2);
            play();
            chk($sformatf("tbl%0d_level", t), 32'(fifo_level), tbl[t].exp_push ? 32'd2 : 32'd1);
            chk($sformatf("tbl%0d_ferr", t), 32'(frame_err), 32'(tbl[t].exp_err));
            if (tbl[t].exp_push) begin
                pop_one();
                chk($sformatf("tbl%0d_pair", t), rd_data, tbl[t].exp_pair);
            end
            pop_one();
            chk($sformatf("tbl%0d_sentinel", t), rd_data, 32'h0F0FF0F0);
            if (tbl[t].exp_err) begin
                pulse_clr();
                chk($sformatf("tbl%0d_ferr_clr", t), 32'(frame_err), 32'd0);
            end
        end

        // Randomized streams against the frame-level model
        for (int round = 0; round < 3; round++) begin
            int n, ll, rl, sel;
            reset_dut();
            add_pad(1'b1, 4);
            n = $urandom_range(3, 10);
            for (int f = 0; f < n; f++) begin
                ll  = $urandom_range(16, 24);
                rl  = $urandom_range(16, 24);
                sel = $urandom_range(0, 7);
                if (sel == 0) ll = $urandom_range(8, 15);
                if (sel == 1) rl = $urandom_range(8, 15);
                add_frame($urandom, $urandom, ll, rl, 1'b0);
            end
            add_pad(1'b0, 2);
            play();
            chk("rand_level", 32'(fifo_level), 32'(exp_q.size()));
            chk("rand_ovf", 32'(overflow), 32'(exp_ovf));
            chk("rand_ferr", 32'(frame_err), 32'(exp_err));
            drain_check("rand_pair");
        end

        // Start alignment: reset released in the middle of a right slot
        reset_dut();
        rst = 1'b1;
        add_pad(1'b1, 4);
        add_raw(32'hDEAD, 32'hBEEF, 16, 16);
        add_frame(32'h1111, 32'hAAAA, 16, 16, 1'b0);
        add_frame(32'h2222, 32'hBBBB, 16, 16, 1'b0);
        add_frame(32'h3333, 32'hCCCC, 16, 16, 1'b0);
        add_pad(1'b0, 2);
        fork
            play();
            begin
                repeat (16*28) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        chk("align_level", 32'(fifo_level), 32'd3);
        chk("align_ferr", 32'(frame_err), 32'd0);
        drain_check("align_pair");

        // Overflow: nine frames, no reads
        reset_dut();
        add_pad(1'b1, 4);
        for (int f = 1; f <= 9; f++) add_frame(32'h1100 + f, 32'h2200 + f, 16, 16, 1'b0);
        add_pad(1'b0, 2);
        play();
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain_check("ovf_pair");
        pulse_clr();
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous push and pop while full
        reset_dut();
        add_pad(1'b1, 4);
        for (int f = 1; f <= 8; f++) add_frame(32'h3300 + f, 32'h4400 + f, 16, 16, 1'b0);
        add_frame(32'h3309, 32'h4409, 16, 16, 1'b1);
        add_pad(1'b0, 2);
        play();
        chk("full_pp_level", 32'(fifo_level), 32'd8);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        chk("full_pp_popped", rd_data, exp_popped);
        drain_check("full_pp_pair");

        // Pop while empty is ignored
        pop_one();
        chk("empty_pop_hold", rd_data, exp_last);
        chk("empty_pop_level", 32'(fifo_level), 32'd0);

        // Reset in the middle of a left slot
        reset_dut();
        add_pad(1'b1, 4);
        add_raw(32'hCAFE, 32'hBABE, 16, 16);
        add_raw(32'h1357, 32'h2468, 16, 16);
        add_raw(32'h5A5A, 32'hA5A5, 16, 16);
        add_pad(1'b0, 2);
        fork
            play();
            begin
                repeat (16*38) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk); #1 rd_en = 1'b0;
                chk("midrst_pre_data", rd_data, 32'hCAFEBABE);
                repeat (16*38 + 2) @(posedge clk);
                #1;
                chk("midrst_pre_level", 32'(fifo_level), 32'd1);
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                chk("midrst_level", 32'(fifo_level), 32'd0);
                chk("midrst_data", rd_data, 32'd0);
                chk("midrst_empty", 32'(rd_empty), 32'd1);
                chk("midrst_flags", {30'd0, overflow, frame_err}, 32'd0);
            end
        join
        chk("midrst_end_level", 32'(fifo_level), 32'd0);
        chk("midrst_end_ferr", 32'(frame_err), 32'd0);

        // Disabled for two frames, re-enabled in the middle of the third
        reset_dut();
        enable = 1'b0;
        add_pad(1'b1, 4);
        add_raw(32'h0101, 32'h0202, 16, 16);
        add_raw(32'h0303, 32'h0404, 16, 16);
        add_raw(32'h0505, 32'h0606, 16, 16);
        add_frame(32'h0707, 32'h0808, 16, 16, 1'b0);
        add_pad(1'b0, 2);
        fork
            play();
            begin
                repeat (16*76) @(posedge clk);
                #1;
                chk("en_off_level", 32'(fifo_level), 32'd0);
                enable = 1'b1;
            end
        join
        chk("en_level", 32'(fifo_level), 32'd1);
        chk("en_ferr", 32'(frame_err), 32'd0);
        drain_check("en_pair");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
